// File: rtl/reorder_tag_manager_pkg.sv
// Shared definitions for the reorder tag manager and the circular buffer's read side:
// verdict status encoding and the mod-N pointer increment.
package reorder_tag_manager_pkg;

    localparam logic [1:0] PENDING = 2'b00;
    localparam logic [1:0] REJECT  = 2'b01;
    localparam logic [1:0] ACCEPT  = 2'b11;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned num);
        return (ptr == num - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/reorder_tag_manager.sv
// Hands out reorder tags, records per-tag filter verdicts and exposes the oldest
// outstanding tag's verdict so the circular buffer can release packets in order.
module reorder_tag_manager
    import reorder_tag_manager_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 6,
    parameter int unsigned NUM_TAGS  = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_grant,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 verdict_valid,
    input  logic [TAG_WIDTH-1:0] verdict_tag,
    input  logic                 verdict_accept,
    output logic [TAG_WIDTH-1:0] head_tag,
    output logic [1:0]           head_status,
    input  logic                 head_done,
    output logic                 full,
    output logic                 empty,
    output logic                 err
);

    localparam int unsigned CountWidth = $clog2(NUM_TAGS + 1);

    logic [TAG_WIDTH-1:0]       head_q, head_d;
    logic [TAG_WIDTH-1:0]       tail_q, tail_d;
    logic [CountWidth-1:0]      count_q, count_d;
    logic [NUM_TAGS-1:0]        in_flight_q, in_flight_d;
    logic [NUM_TAGS-1:0][1:0]   status_q, status_d;
    logic                       err_q, err_d;

    logic       grant;
    logic       verdict_ok;
    logic       done_ok;
    logic [1:0] head_stat;
    logic       vt_found;
    logic       vt_in_flight;
    logic [1:0] vt_status;

    // Table lookups by decode; an out-of-range verdict_tag simply finds no entry.
    always_comb begin
        head_stat    = PENDING;
        vt_found     = 1'b0;
        vt_in_flight = 1'b0;
        vt_status    = PENDING;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (head_q == TAG_WIDTH'(i)) begin
                head_stat = status_q[i];
            end
            if (verdict_tag == TAG_WIDTH'(i)) begin
                vt_found     = 1'b1;
                vt_in_flight = in_flight_q[i];
                vt_status    = status_q[i];
            end
        end
    end

    assign full        = (count_q == CountWidth'(NUM_TAGS));
    assign empty       = (count_q == '0);
    assign grant       = alloc_req & ~full;
    assign alloc_grant = grant;
    assign alloc_tag   = tail_q;
    assign head_tag    = head_q;
    assign head_status = empty ? PENDING : head_stat;
    assign err         = err_q;

    assign verdict_ok = verdict_valid & vt_found & vt_in_flight & (vt_status == PENDING);
    assign done_ok    = head_done & ~empty & (head_status != PENDING);

    always_comb begin
        in_flight_d = in_flight_q;
        status_d    = status_q;
        head_d      = head_q;
        tail_d      = tail_q;
        err_d       = err_q | (verdict_valid & ~verdict_ok) | (head_done & ~done_ok);
        count_d     = count_q + CountWidth'(grant) - CountWidth'(done_ok);

        // Grant, verdict and retire never hit the same entry in one cycle.
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (grant && tail_q == TAG_WIDTH'(i)) begin
                in_flight_d[i] = 1'b1;
                status_d[i]    = PENDING;
            end
            if (verdict_ok && verdict_tag == TAG_WIDTH'(i)) begin
                status_d[i] = verdict_accept ? ACCEPT : REJECT;
            end
            if (done_ok && head_q == TAG_WIDTH'(i)) begin
                in_flight_d[i] = 1'b0;
                status_d[i]    = PENDING;
            end
        end

        if (grant) begin
            tail_d = TAG_WIDTH'(ptr_inc(32'(tail_q), NUM_TAGS));
        end
        if (done_ok) begin
            head_d = TAG_WIDTH'(ptr_inc(32'(head_q), NUM_TAGS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            status_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            status_q    <= status_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_reorder_tag_manager.sv
// Directed bench for reorder_tag_manager: allocation, verdicts, in-order drain,
// full/wrap behaviour, protocol errors and reset.
module tb_reorder_tag_manager;

    localparam int unsigned TW = 6;
    localparam int unsigned NT = 50;

    logic          clk;
    logic          rst;
    logic          alloc_req;
    logic          alloc_grant;
    logic [TW-1:0] alloc_tag;
    logic          verdict_valid;
    logic [TW-1:0] verdict_tag;
    logic          verdict_accept;
    logic [TW-1:0] head_tag;
    logic [1:0]    head_status;
    logic          head_done;
    logic          full;
    logic          empty;
    logic          err;

    int errors = 0;
    int checks = 0;

    reorder_tag_manager #(
        .TAG_WIDTH(TW),
        .NUM_TAGS (NT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (alloc_req),
        .alloc_grant   (alloc_grant),
        .alloc_tag     (alloc_tag),
        .verdict_valid (verdict_valid),
        .verdict_tag   (verdict_tag),
        .verdict_accept(verdict_accept),
        .head_tag      (head_tag),
        .head_status   (head_status),
        .head_done     (head_done),
        .full          (full),
        .empty         (empty),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle 1 time unit past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req      = 1'b0;
        verdict_valid  = 1'b0;
        verdict_tag    = '0;
        verdict_accept = 1'b0;
        head_done      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_n(input int n);
        alloc_req = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        alloc_req = 1'b0;
        #1;
    endtask

    task automatic send_verdict(input logic [TW-1:0] tag, input logic acc);
        verdict_valid  = 1'b1;
        verdict_tag    = tag;
        verdict_accept = acc;
        cycle();
        verdict_valid  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: empty=%b full=%b, want empty=1 full=0", empty, full);
        end
        checks++;
        if (head_tag !== 6'd0 || head_status !== 2'b00 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_head: tag=%0d st=%b err=%b, want 0 00 0",
                     head_tag, head_status, err);
        end
        alloc_req = 1'b1;
        #1;
        checks++;
        if (alloc_grant !== 1'b1 || alloc_tag !== 6'd0) begin
            errors++;
            $display("FAIL reset_grant: grant=%b tag=%0d, want 1 0", alloc_grant, alloc_tag);
        end
        alloc_req = 1'b0;
        #1;
        checks++;
        if (alloc_grant !== 1'b0) begin
            errors++;
            $display("FAIL reset_nogrant: grant=%b, want 0", alloc_grant);
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp_st [3];
        exp_st = '{2'b11, 2'b01, 2'b11};
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (alloc_grant !== 1'b1 || alloc_tag !== TW'(i)) begin
                errors++;
                $display("FAIL basic_alloc%0d: grant=%b tag=%0d, want 1 %0d",
                         i, alloc_grant, alloc_tag, i);
            end
            cycle();
        end
        alloc_req = 1'b0;
        send_verdict(6'd0, 1'b1);
        send_verdict(6'd1, 1'b0);
        send_verdict(6'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (head_tag !== TW'(i) || head_status !== exp_st[i]) begin
                errors++;
                $display("FAIL basic_head%0d: tag=%0d st=%b, want %0d %b",
                         i, head_tag, head_status, i, exp_st[i]);
            end
            head_done = 1'b1;
            cycle();
            head_done = 1'b0;
        end
        checks++;
        if (empty !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: empty=%b err=%b, want 1 0", empty, err);
        end
    endtask

    task automatic test_out_of_order();
        logic [1:0] exp_st [4];
        exp_st = '{2'b11, 2'b01, 2'b01, 2'b11};
        do_reset();
        alloc_n(4);
        send_verdict(6'd3, 1'b1);
        checks++;
        if (head_status !== 2'b00) begin
            errors++;
            $display("FAIL ooo_after3: st=%b, want 00", head_status);
        end
        send_verdict(6'd1, 1'b0);
        checks++;
        if (head_status !== 2'b00) begin
            errors++;
            $display("FAIL ooo_after1: st=%b, want 00", head_status);
        end
        send_verdict(6'd0, 1'b1);
        checks++;
        if (head_status !== 2'b11 || head_tag !== 6'd0) begin
            errors++;
            $display("FAIL ooo_after0: tag=%0d st=%b, want 0 11", head_tag, head_status);
        end
        send_verdict(6'd2, 1'b0);
        head_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (head_tag !== TW'(i) || head_status !== exp_st[i]) begin
                errors++;
                $display("FAIL ooo_drain%0d: tag=%0d st=%b, want %0d %b",
                         i, head_tag, head_status, i, exp_st[i]);
            end
            cycle();
        end
        head_done = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL ooo_end: empty=%b err=%b, want 1 0", empty, err);
        end
    endtask

    task automatic test_fill();
        int bad = 0;
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            checks++;
            if (alloc_grant !== 1'b1 || alloc_tag !== TW'(i)) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL fill_alloc%0d: grant=%b tag=%0d, want 1 %0d",
                                      i, alloc_grant, alloc_tag, i);
            end
            cycle();
        end
        checks++;
        if (full !== 1'b1 || alloc_grant !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b grant=%b, want 1 0", full, alloc_grant);
        end
        send_verdict(6'd0, 1'b1);
        head_done = 1'b1;
        #1;
        checks++;
        if (alloc_grant !== 1'b0 || head_status !== 2'b11) begin
            errors++;
            $display("FAIL fill_done_nogrant: grant=%b st=%b, want 0 11",
                     alloc_grant, head_status);
        end
        cycle();
        head_done = 1'b0;
        #1;
        checks++;
        if (alloc_grant !== 1'b1 || alloc_tag !== 6'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL fill_wrap: grant=%b tag=%0d full=%b, want 1 0 0",
                     alloc_grant, alloc_tag, full);
        end
        cycle();
        alloc_req = 1'b0;
        #1;
        checks++;
        if (full !== 1'b1 || head_tag !== 6'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL fill_refull: full=%b head=%0d err=%b, want 1 1 0",
                     full, head_tag, err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        send_verdict(6'd5, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_unalloc: err=%b, want 1", err);
        end
        cycle();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end

        do_reset();
        alloc_n(1);
        send_verdict(6'd0, 1'b1);
        checks++;
        if (err !== 1'b0 || head_status !== 2'b11) begin
            errors++;
            $display("FAIL err_first_verdict: err=%b st=%b, want 0 11", err, head_status);
        end
        send_verdict(6'd0, 1'b0);
        checks++;
        if (err !== 1'b1 || head_status !== 2'b11) begin
            errors++;
            $display("FAIL err_dup: err=%b st=%b, want 1 11", err, head_status);
        end

        do_reset();
        alloc_n(1);
        head_done = 1'b1;
        cycle();
        head_done = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1 || empty !== 1'b0 || head_tag !== 6'd0) begin
            errors++;
            $display("FAIL err_done_pending: err=%b empty=%b head=%0d, want 1 0 0",
                     err, empty, head_tag);
        end

        do_reset();
        alloc_n(1);
        send_verdict(6'd55, 1'b1);
        checks++;
        if (err !== 1'b1 || head_status !== 2'b00) begin
            errors++;
            $display("FAIL err_range: err=%b st=%b, want 1 00", err, head_status);
        end

        do_reset();
        alloc_req      = 1'b1;
        verdict_valid  = 1'b1;
        verdict_tag    = 6'd0;
        verdict_accept = 1'b1;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (err !== 1'b1 || head_status !== 2'b00 || empty !== 1'b0) begin
            errors++;
            $display("FAIL err_same_cycle: err=%b st=%b empty=%b, want 1 00 0",
                     err, head_status, empty);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        alloc_n(10);
        send_verdict(6'd0, 1'b1);
        // Grant tag 10, retire tag 0 and record tag 1's verdict in one cycle.
        alloc_req      = 1'b1;
        head_done      = 1'b1;
        verdict_valid  = 1'b1;
        verdict_tag    = 6'd1;
        verdict_accept = 1'b1;
        #1;
        checks++;
        if (alloc_grant !== 1'b1 || alloc_tag !== 6'd10) begin
            errors++;
            $display("FAIL b2b_grant: grant=%b tag=%0d, want 1 10", alloc_grant, alloc_tag);
        end
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (head_tag !== 6'd1 || head_status !== 2'b11 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_head: tag=%0d st=%b err=%b, want 1 11 0",
                     head_tag, head_status, err);
        end
        // Count stayed at 10, so exactly 40 more grants fit.
        alloc_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            checks++;
            if (alloc_grant !== 1'b1 || alloc_tag !== TW'((11 + i) % 50)) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL b2b_fill%0d: grant=%b tag=%0d, want 1 %0d",
                                      i, alloc_grant, alloc_tag, (11 + i) % 50);
            end
            cycle();
        end
        checks++;
        if (full !== 1'b1 || alloc_grant !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: full=%b grant=%b, want 1 0", full, alloc_grant);
        end
        alloc_req = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_n(20);
        send_verdict(6'd0, 1'b1);
        send_verdict(6'd40, 1'b1);
        checks++;
        if (err !== 1'b1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup: err=%b empty=%b, want 1 0", err, empty);
        end
        do_reset();
        checks++;
        if (empty !== 1'b1 || head_tag !== 6'd0 || err !== 1'b0 || head_status !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: empty=%b head=%0d err=%b st=%b, want 1 0 0 00",
                     empty, head_tag, err, head_status);
        end
        alloc_req = 1'b1;
        #1;
        checks++;
        if (alloc_grant !== 1'b1 || alloc_tag !== 6'd0) begin
            errors++;
            $display("FAIL mid_grant: grant=%b tag=%0d, want 1 0", alloc_grant, alloc_tag);
        end
        alloc_req = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_out_of_order();
        test_fill();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reorder_tag_manager.md
# reorder_tag_manager

Allocates reorder tags to packets entering the parallel filter cores, collects each core's accept/reject verdict per tag, and presents the verdict of the oldest outstanding tag to the circular buffer's read side. It sits between the forwarder (allocation), the filter cores (verdicts) and the circular buffer (in-order drain). It guarantees in-order release and prevents tag reuse before the buffer has drained that tag.

## Interface
- TAG_WIDTH, 6, width of a reorder tag
- NUM_TAGS, 50, number of tags in circulation; must be ≤ 2^TAG_WIDTH and ≥ 2; need not be a power of two
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- alloc_req  in  1  forwarder requests a tag for a new packet
- alloc_grant  out  1  tag granted this cycle
- alloc_tag  out  TAG_WIDTH  tag granted (valid when alloc_grant)
- verdict_valid  in  1  a filter core reports a verdict
- verdict_tag  in  TAG_WIDTH  tag the verdict applies to
- verdict_accept  in  1  1 = accept, 0 = reject
- head_tag  out  TAG_WIDTH  oldest outstanding tag
- head_status  out  2  status of head_tag: 00 pending, 01 reject, 11 accept; 10 never driven
- head_done  in  1  buffer has finished the head tag (last beat sent, or reject skipped)
- full  out  1  NUM_TAGS tags outstanding
- empty  out  1  no tags outstanding
- err  out  1  sticky protocol-error flag, cleared only by rst

## Operation
- State:
  - head and tail pointers, each wrapping NUM_TAGS-1 → 0
  - count, width $clog2(NUM_TAGS+1)
  - per-tag in_flight bit and 2-bit status
- Allocation:
  - alloc_grant = alloc_req & ~full (combinational); alloc_tag = tail.
  - On grant: in_flight[tail] ← 1, status[tail] ← 00, tail advances.
- Verdict, accepted only if verdict_valid, verdict_tag < NUM_TAGS, in_flight[verdict_tag] = 1 and status[verdict_tag] = 00:
  - accepted verdict writes status 11 if verdict_accept, else 01.
  - Any other verdict_valid is dropped and sets err.
- Drain:
  - head_tag = head; head_status = status[head] when ~empty, else 00.
  - head_done is accepted only if ~empty and head_status ≠ 00. On acceptance: in_flight[head] ← 0, status[head] ← 00, head advances.
  - Any other head_done is ignored and sets err.
- count ← count + grant − done_accepted; full = (count == NUM_TAGS); empty = (count == 0).
- Simultaneous events:
  - Grant and done in the same cycle: count unchanged, both pointers advance.
  - When full, a same-cycle done does not enable a grant; the grant happens on the next cycle.
  - A verdict to the tag granted in the same cycle is dropped (err), because that tag is not yet in_flight.
  - A verdict and an accepted done to different tags in the same cycle both take effect.
- Reset: head = tail = count = 0, all in_flight and status cleared, err = 0. Outputs after reset: full = 0, empty = 1, head_tag = 0, head_status = 00, alloc_grant follows alloc_req. Reset mid-operation discards all outstanding tags without draining them.

## Timing
- alloc_grant and alloc_tag are combinational from alloc_req and registered state, giving zero-cycle grant.
- A tag granted at edge N can accept a verdict at edge N+1 at the earliest.
- A verdict accepted at edge N is visible on head_status after edge N (same-cycle combinational read of registered status).
- head_done at edge N: the new head_tag and head_status are visible after edge N, so one tag can retire per cycle.
- No internal pipeline; every state update happens on the single rising edge.

## Structure
- Shared package holds:
  - status encoding constants: PENDING = 2'b00, REJECT = 2'b01, ACCEPT = 2'b11
  - a mod-N pointer-increment function used by this block and the circular buffer
- The same status encoding drives the circular buffer's packet_status input.
- Single module, no sub-modules; the status table is a flat register array (NUM_TAGS × 2 bits, plus in_flight).

## Test plan
- Reset, then 3 grants, verdicts accept/reject/accept on tags 0/1/2, head_done each time head_status ≠ 00 → head_status sequence 11, 01, 11; tags 0, 1, 2 retire in order; empty = 1 after; err = 0.
- Out-of-order verdicts: allocate 0..3, verdict tag 3 then 1 then 0 then 2 → head_status stays 00 until tag 0 verdict, then tags 0, 1, 2, 3 retire on consecutive cycles.
- Fill: 50 grants → full = 1 and alloc_grant = 0 on the 51st request. Same cycle as a head_done → no grant that cycle, grant of tag 0 next cycle. Tail wraps 49 → 0.
- Errors:
  - verdict to an unallocated tag → dropped, err = 1
  - duplicate verdict to tag 0 → dropped, status unchanged
  - head_done while head_status = 00 → ignored
  - verdict_tag = 55 → dropped
- Same-cycle grant and done at count = 10 → count stays 10, both pointers advance by 1.
- Assert rst with 20 tags outstanding → next cycle empty = 1, head_tag = 0, err = 0, and the first grant returns tag 0.
